// File: rtl/adc_ref_clk_ctrl.sv
// adc_ref_clk_ctrl: lock-gated, divided, glitch-free ADC reference clock sequencer driving ODDR D1/D2
module adc_ref_clk_ctrl #(
  parameter int LOCK_WAIT      = 1024,
  parameter int ADC_RST_CYCLES = 256,
  parameter int SETTLE_CYCLES  = 4096,
  parameter int DIV_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mmcm_locked,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div_ratio,
  output logic                 oddr_d1,
  output logic                 oddr_d2,
  output logic                 adc_rst,
  output logic                 clk_running,
  output logic                 adc_ready,
  output logic                 lock_lost
);
  localparam int LW   = $clog2(LOCK_WAIT + 1);
  localparam int SMAX = (ADC_RST_CYCLES > SETTLE_CYCLES) ? ADC_RST_CYCLES : SETTLE_CYCLES;
  localparam int CW   = $clog2(SMAX + 1);
  typedef enum logic [2:0] {IDLE, WAIT_LOCK, START, SETTLE, READY, STOP} state_t;
  state_t state, next;
  logic s1, lk, lost, run;
  logic [LW-1:0] lock_cnt;
  logic [CW-1:0] cnt;
  logic [DIV_WIDTH-1:0] n, ph;
  assign run = state inside {START, SETTLE, READY, STOP};
  always_comb begin
    next = state;
    case (state)
      IDLE:      next = enable ? WAIT_LOCK : IDLE;
      WAIT_LOCK: next = !enable ? IDLE : (lk && lock_cnt == LW'(LOCK_WAIT)) ? START : WAIT_LOCK;
      START:     next = !lk ? WAIT_LOCK : !enable ? STOP : (cnt == CW'(ADC_RST_CYCLES - 1)) ? SETTLE : START;
      SETTLE:    next = !lk ? WAIT_LOCK : !enable ? STOP : (cnt == CW'(SETTLE_CYCLES - 1)) ? READY : SETTLE;
      READY:     next = !lk ? WAIT_LOCK : !enable ? STOP : READY;
      STOP:      next = !lk ? WAIT_LOCK : (ph == n - DIV_WIDTH'(1)) ? IDLE : STOP;
      default:   next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      s1          <= 1'b0;
      lk          <= 1'b0;
      lock_cnt    <= '0;
      cnt         <= '0;
      n           <= '0;
      ph          <= '0;
      lost        <= 1'b0;
      oddr_d1     <= 1'b0;
      oddr_d2     <= 1'b0;
      adc_rst     <= 1'b1;
      clk_running <= 1'b0;
      adc_ready   <= 1'b0;
      lock_lost   <= 1'b0;
    end else begin
      state       <= next;
      s1          <= mmcm_locked;
      lk          <= s1;
      lock_cnt    <= (state == WAIT_LOCK && next == WAIT_LOCK && lk) ? lock_cnt + LW'(1) : '0;
      cnt         <= ((state == START || state == SETTLE) && next == state) ? cnt + CW'(1) : '0;
      ph          <= (run && ph != n - DIV_WIDTH'(1)) ? ph + DIV_WIDTH'(1) : '0;
      if (state == WAIT_LOCK && next == START)
        n <= (div_ratio == '0) ? DIV_WIDTH'(1) : div_ratio;
      lost        <= (run && !lk) ? 1'b1 : (state == IDLE && enable) ? 1'b0 : lost;
      // Outputs trail the state by one edge; a half-cycle is high while 2*ph(+1) < N.
      oddr_d1     <= run && ({ph, 1'b0} < {1'b0, n});
      oddr_d2     <= run && ({ph, 1'b1} < {1'b0, n});
      adc_rst     <= !(state == SETTLE || state == READY);
      clk_running <= run;
      adc_ready   <= state == READY;
      lock_lost   <= lost;
    end
  end
endmodule

// File: doc/adc_ref_clk_ctrl.md
# adc_ref_clk_ctrl

Sequencer for the forwarded ADC reference clock. It drives the D1/D2 data pins of the ODDR that feeds the differential ADC clock output buffer: start-up gated on MMCM lock, a programmable clock divider, ADC reset sequencing and glitch-free stop. It sits between the clocking wizard (lock) and the ADC-facing clock forwarding primitive. All logic is in the fabric clock domain that clocks the ODDR.

## Interface
- LOCK_WAIT, 1024: consecutive synchronized lock-high cycles required before the clock starts
- ADC_RST_CYCLES, 256: cycles adc_rst stays high after the clock starts
- SETTLE_CYCLES, 4096: cycles after adc_rst release before adc_ready
- DIV_WIDTH, 8: width of div_ratio
- clk  in  1  fabric clock; also the ODDR clock
- rst  in  1  synchronous, active-high reset
- mmcm_locked  in  1  asynchronous MMCM lock, double-flop synchronized internally
- enable  in  1  request to run the ADC clock
- div_ratio  in  DIV_WIDTH  output period in clk cycles; 0 is treated as 1
- oddr_d1  out  1  ODDR D1, first half-cycle value
- oddr_d2  out  1  ODDR D2, second half-cycle value
- adc_rst  out  1  ADC reset, active high
- clk_running  out  1  forwarded clock toggling
- adc_ready  out  1  sequence complete, ADC usable
- lock_lost  out  1  sticky: lock dropped while running

## Operation
- **Reset values:** oddr_d1=0, oddr_d2=0, adc_rst=1, clk_running=0, adc_ready=0, lock_lost=0, state IDLE, all counters 0. All outputs are registered.
- **Lock signal:** lk is mmcm_locked after two flops.
- **States:** IDLE, WAIT_LOCK, START, SETTLE, READY, STOP.
  - IDLE: d1=d2=0, adc_rst=1. If enable=1, go to WAIT_LOCK and clear lock_lost.
  - WAIT_LOCK: lock_cnt increments while lk=1 and clears to 0 when lk=0. When lock_cnt reaches LOCK_WAIT, latch N=max(div_ratio,1), clear the phase counter and go to START.
  - START: the clock toggles and adc_rst=1. After ADC_RST_CYCLES cycles in START, go to SETTLE.
  - SETTLE: the clock toggles and adc_rst=0. After SETTLE_CYCLES cycles, go to READY.
  - READY: adc_ready=1.
  - STOP: the clock keeps toggling until ph=N-1, then go to IDLE with d1=d2=0. This guarantees the last high phase is complete.
- **Enable drop:** enable=0 in WAIT_LOCK goes directly to IDLE. enable=0 in START, SETTLE or READY goes to STOP. adc_ready drops and adc_rst rises on STOP entry.
- **Lock loss:** lk=0 in START, SETTLE, READY or STOP forces WAIT_LOCK.
  - d1=d2=0 immediately (next edge).
  - adc_rst=1, adc_ready=0, lock_lost=1.
  - lock_lost stays set until IDLE→WAIT_LOCK or rst.
  - Lock loss has priority over enable=0.
- **Divider:** phase counter ph runs 0..N-1 and wraps. Output values: d1=(2·ph < N), d2=(2·ph+1 < N).
  - N=1: d1=1, d2=0 every cycle, giving full rate.
  - N=2: pattern (1,1),(0,0).
  - N=3: pattern (1,1),(1,0),(0,0), which is 50% duty at half-cycle resolution.
  - Comparisons use DIV_WIDTH+1 bits so they do not overflow.
  - div_ratio changes while running are ignored until the next WAIT_LOCK→START.
- **Flags:** clk_running=1 exactly in START, SETTLE, READY and STOP.

## Timing
- lk follows mmcm_locked 2 cycles late.
- With enable already high, the first d1=1 (ph=0) appears at edge LOCK_WAIT+3 after the edge that first samples mmcm_locked=1. clk_running rises on the same edge.
- adc_rst falls exactly ADC_RST_CYCLES edges after clk_running rises.
- adc_ready rises exactly SETTLE_CYCLES edges after adc_rst falls.
- Lock drop: outputs go quiet 3 edges after mmcm_locked falls (2 synchronizer edges + 1).
- Stop latency: enable=0 to IDLE takes at most N+1 edges. If enable returns to 1 during STOP, the block still completes to IDLE, then re-enters WAIT_LOCK on the next cycle.
- rst mid-operation: all outputs return to their reset values on the next edge, with no draining.

## Test plan
Parameters for all scenarios: LOCK_WAIT=4, ADC_RST_CYCLES=3, SETTLE_CYCLES=5.
1. Start-up: rst released, enable=1, mmcm_locked=1 at edge 0, div_ratio=1 → d1/d2=(1,0) from edge 7; adc_rst falls at edge 10; adc_ready rises at edge 15.
2. Divider: div_ratio=0, 2 and 3 on successive runs → (1,0) repeating for 0; period (1,1),(0,0) for 2; period (1,1),(1,0),(0,0) for 3.
3. Lock glitch during WAIT_LOCK: lock low for 1 cycle after 3 good cycles → lock_cnt restarts and the start is delayed by 4 extra cycles; lock_lost stays 0.
4. Lock loss in READY: lock low → 3 edges later d1=d2=0, adc_rst=1, adc_ready=0, lock_lost=1. Lock returns → full sequence repeats and lock_lost remains 1 until re-enable from IDLE.
5. Enable drop with div_ratio=4 at ph=1 → output continues through ph=2,3, then d1=d2=0 and clk_running=0; no runt pulse.
6. rst asserted in SETTLE → next edge shows all outputs at reset values, state IDLE.
